// File: rtl/native_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : native_port_arbiter
// Purpose  : Shares one valid-ready native memory port between two native
//            masters (m0 = instruction-side bridge, m1 = data-side bridge).
//            Requests are arbitrated round-robin, and a grant is locked while
//            memory back-pressures it, so an offered request stays stable
//            until it is accepted. The owner of every in-flight read is kept
//            in an in-order tag FIFO, and each memory response is steered
//            back to that owner.
// Ports    : clk, reset             - clock, synchronous active-high reset
//            m{0,1}_request_*       - master request channels (valid/ready/
//                                     op/addr/data)
//            m{0,1}_update_*        - master read-response channels
//            mem_request_*          - shared memory request channel
//            mem_update_*           - shared memory response channel
//            reads_outstanding      - in-flight read count
// Revision : 1.0 - initial release
// ============================================================================
module native_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int MAX_READS  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  // master 0
  input  logic                           m0_request_valid,
  output logic                           m0_request_ready,
  input  logic [1:0]                     m0_request_op,
  input  logic [ADDR_WIDTH-1:0]          m0_request_addr,
  input  logic [DATA_WIDTH-1:0]          m0_request_data,
  output logic                           m0_update_valid,
  input  logic                           m0_update_ready,
  output logic [DATA_WIDTH-1:0]          m0_update_data,
  // master 1
  input  logic                           m1_request_valid,
  output logic                           m1_request_ready,
  input  logic [1:0]                     m1_request_op,
  input  logic [ADDR_WIDTH-1:0]          m1_request_addr,
  input  logic [DATA_WIDTH-1:0]          m1_request_data,
  output logic                           m1_update_valid,
  input  logic                           m1_update_ready,
  output logic [DATA_WIDTH-1:0]          m1_update_data,
  // memory side
  output logic                           mem_request_valid,
  input  logic                           mem_request_ready,
  output logic [1:0]                     mem_request_op,
  output logic [ADDR_WIDTH-1:0]          mem_request_addr,
  output logic [DATA_WIDTH-1:0]          mem_request_data,
  input  logic                           mem_update_valid,
  output logic                           mem_update_ready,
  input  logic [DATA_WIDTH-1:0]          mem_update_data,
  output logic [$clog2(MAX_READS+1)-1:0] reads_outstanding
);

  localparam int         c_CW    = $clog2(MAX_READS + 1);
  localparam int         c_PW    = (MAX_READS > 1) ? $clog2(MAX_READS) : 1;
  localparam logic [1:0] c_OP_RD = 2'b01;
  localparam logic [1:0] c_OP_WR = 2'b10;
  localparam logic [c_CW-1:0] c_MAX_CNT  = c_CW'(MAX_READS);
  localparam logic [c_PW-1:0] c_LAST_PTR = c_PW'(MAX_READS - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic            r_rr;        // master favoured when both are eligible
  logic            r_lock;
  logic            r_lock_id;
  logic [c_CW-1:0] r_count;
  logic [c_PW-1:0] r_wr_ptr;
  logic [c_PW-1:0] r_rd_ptr;
  logic            r_tag [MAX_READS];

  // --------------------------------------------------------------------------
  // Request arbitration
  // --------------------------------------------------------------------------
  logic            w_reads_full;
  logic            w_elig0;
  logic            w_elig1;
  logic            w_have_owner;
  logic            w_owner;
  logic            w_owner_valid;
  logic [1:0]      w_owner_op;
  logic [ADDR_WIDTH-1:0] w_owner_addr;
  logic [DATA_WIDTH-1:0] w_owner_data;
  logic            w_legal;
  logic            w_grant_ready;
  logic            w_push;
  logic            w_pop;
  logic            w_fifo_empty;
  logic            w_target;

  assign w_reads_full = (r_count >= c_MAX_CNT);

  // Writes and illegal ops are never limited by the read budget; illegal ops
  // are granted like writes so they can be consumed and dropped.
  assign w_elig0 = m0_request_valid && ((m0_request_op != c_OP_RD) || !w_reads_full);
  assign w_elig1 = m1_request_valid && ((m1_request_op != c_OP_RD) || !w_reads_full);

  assign w_have_owner = r_lock || w_elig0 || w_elig1;

  always_comb begin
    w_owner = 1'b0;
    if (r_lock) begin
      w_owner = r_lock_id;
    end else if (w_elig0 && w_elig1) begin
      w_owner = r_rr;
    end else if (w_elig1) begin
      w_owner = 1'b1;
    end
  end

  assign w_owner_valid = w_owner ? m1_request_valid : m0_request_valid;
  assign w_owner_op    = w_owner ? m1_request_op    : m0_request_op;
  assign w_owner_addr  = w_owner ? m1_request_addr  : m0_request_addr;
  assign w_owner_data  = w_owner ? m1_request_data  : m0_request_data;
  assign w_legal       = (w_owner_op == c_OP_RD) || (w_owner_op == c_OP_WR);

  assign mem_request_valid = !reset && w_have_owner && w_owner_valid && w_legal;
  assign mem_request_op    = mem_request_valid ? w_owner_op   : 2'b00;
  assign mem_request_addr  = mem_request_valid ? w_owner_addr : '0;
  assign mem_request_data  = mem_request_valid ? w_owner_data : '0;

  // Illegal ops are acknowledged locally without waiting for memory.
  assign w_grant_ready = !reset && w_have_owner && w_owner_valid &&
                         (w_legal ? mem_request_ready : 1'b1);

  assign m0_request_ready = w_grant_ready && (w_owner == 1'b0);
  assign m1_request_ready = w_grant_ready && (w_owner == 1'b1);

  assign w_push = mem_request_valid && mem_request_ready && (w_owner_op == c_OP_RD);

  // --------------------------------------------------------------------------
  // Response routing
  // --------------------------------------------------------------------------
  assign w_fifo_empty = (r_count == '0);
  assign w_target     = r_tag[r_rd_ptr];

  assign mem_update_ready = !reset && !w_fifo_empty &&
                            (w_target ? m1_update_ready : m0_update_ready);
  assign m0_update_valid  = !reset && !w_fifo_empty && (w_target == 1'b0) && mem_update_valid;
  assign m1_update_valid  = !reset && !w_fifo_empty && (w_target == 1'b1) && mem_update_valid;
  assign m0_update_data   = reset ? '0 : mem_update_data;
  assign m1_update_data   = reset ? '0 : mem_update_data;

  assign w_pop = mem_update_valid && mem_update_ready;

  assign reads_outstanding = r_count;

  // --------------------------------------------------------------------------
  // Sequential control
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr      <= 1'b0;
      r_lock    <= 1'b0;
      r_lock_id <= 1'b0;
      r_count   <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
    end else begin
      if (w_grant_ready) begin
        r_rr   <= ~w_owner;
        r_lock <= 1'b0;
      end else if (mem_request_valid) begin
        // Memory stalled an offered request: hold this owner until accepted.
        r_lock    <= 1'b1;
        r_lock_id <= w_owner;
      end

      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Tag storage needs no reset: entries are only read while the count says
  // they hold a live tag.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag[r_wr_ptr] <= w_owner;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_native_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_native_port_arbiter
// Purpose  : Directed self-checking bench for native_port_arbiter: reset
//            state, single read, round-robin writes, grant locking, read
//            budget limit, response back-pressure, illegal op drop and
//            reset with traffic in flight.
// Revision : 1.0 - initial release
// ============================================================================
module tb_native_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 256;
  localparam int MR = 4;
  localparam int CW = $clog2(MR + 1);

  logic          clk;
  logic          reset;
  logic          m0_request_valid, m0_request_ready;
  logic [1:0]    m0_request_op;
  logic [AW-1:0] m0_request_addr;
  logic [DW-1:0] m0_request_data;
  logic          m0_update_valid, m0_update_ready;
  logic [DW-1:0] m0_update_data;
  logic          m1_request_valid, m1_request_ready;
  logic [1:0]    m1_request_op;
  logic [AW-1:0] m1_request_addr;
  logic [DW-1:0] m1_request_data;
  logic          m1_update_valid, m1_update_ready;
  logic [DW-1:0] m1_update_data;
  logic          mem_request_valid, mem_request_ready;
  logic [1:0]    mem_request_op;
  logic [AW-1:0] mem_request_addr;
  logic [DW-1:0] mem_request_data;
  logic          mem_update_valid, mem_update_ready;
  logic [DW-1:0] mem_update_data;
  logic [CW-1:0] reads_outstanding;

  int n_cmp;
  int n_err;

  native_port_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MAX_READS (MR)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .m0_request_valid  (m0_request_valid),
    .m0_request_ready  (m0_request_ready),
    .m0_request_op     (m0_request_op),
    .m0_request_addr   (m0_request_addr),
    .m0_request_data   (m0_request_data),
    .m0_update_valid   (m0_update_valid),
    .m0_update_ready   (m0_update_ready),
    .m0_update_data    (m0_update_data),
    .m1_request_valid  (m1_request_valid),
    .m1_request_ready  (m1_request_ready),
    .m1_request_op     (m1_request_op),
    .m1_request_addr   (m1_request_addr),
    .m1_request_data   (m1_request_data),
    .m1_update_valid   (m1_update_valid),
    .m1_update_ready   (m1_update_ready),
    .m1_update_data    (m1_update_data),
    .mem_request_valid (mem_request_valid),
    .mem_request_ready (mem_request_ready),
    .mem_request_op    (mem_request_op),
    .mem_request_addr  (mem_request_addr),
    .mem_request_data  (mem_request_data),
    .mem_update_valid  (mem_update_valid),
    .mem_update_ready  (mem_update_ready),
    .mem_update_data   (mem_update_data),
    .reads_outstanding (reads_outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_request_valid = 0; m0_request_op = 2'b00; m0_request_addr = '0; m0_request_data = '0;
    m1_request_valid = 0; m1_request_op = 2'b00; m1_request_addr = '0; m1_request_data = '0;
    m0_update_ready = 0; m1_update_ready = 0;
    mem_request_ready = 0; mem_update_valid = 0; mem_update_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1;
    idle_inputs();
    tick();

    // ---- Reset state: outputs held at zero even with live inputs ----
    m0_request_valid = 1; m0_request_op = 2'b01; m0_request_addr = 32'h100;
    mem_request_ready = 1; mem_update_valid = 1; mem_update_data = 256'h55;
    m0_update_ready = 1;
    #1;
    chk("rst_m0_req_ready", m0_request_ready, 0);
    chk("rst_mem_req_valid", mem_request_valid, 0);
    chk("rst_mem_req_addr", mem_request_addr, 0);
    chk("rst_mem_upd_ready", mem_update_ready, 0);
    chk("rst_m0_upd_valid", m0_update_valid, 0);
    chk("rst_m0_upd_data", m0_update_data, 0);
    tick();
    chk("rst_count", reads_outstanding, 0);
    idle_inputs();
    reset = 0;
    tick();

    // ---- Single read by m0 ----
    m0_request_valid = 1; m0_request_op = 2'b01; m0_request_addr = 32'h100;
    mem_request_ready = 1;
    #1;
    chk("rd_mem_valid", mem_request_valid, 1);
    chk("rd_mem_op", mem_request_op, 2'b01);
    chk("rd_mem_addr", mem_request_addr, 32'h100);
    chk("rd_m0_ready", m0_request_ready, 1);
    chk("rd_m1_ready", m1_request_ready, 0);
    chk("rd_count0", reads_outstanding, 0);
    tick();
    chk("rd_count1", reads_outstanding, 1);
    idle_inputs();
    mem_update_valid = 1; mem_update_data = 256'hAA;
    m0_update_ready = 1; m1_update_ready = 1;
    #1;
    chk("rsp_m0_valid", m0_update_valid, 1);
    chk("rsp_m0_data", m0_update_data, 256'hAA);
    chk("rsp_m1_valid", m1_update_valid, 0);
    chk("rsp_mem_ready", mem_update_ready, 1);
    tick();
    chk("rsp_count0", reads_outstanding, 0);

    // ---- Round-robin writes: m0,m1,m0,m1 ----
    do_reset();
    m0_request_valid = 1; m0_request_op = 2'b10; m0_request_addr = 32'h200; m0_request_data = 256'hD0;
    m1_request_valid = 1; m1_request_op = 2'b10; m1_request_addr = 32'h300; m1_request_data = 256'hD1;
    mem_request_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr%0d_m0_ready", i), m0_request_ready, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("rr%0d_m1_ready", i), m1_request_ready, (i % 2 == 1) ? 1 : 0);
      chk($sformatf("rr%0d_addr", i), mem_request_addr, (i % 2 == 0) ? 32'h200 : 32'h300);
      chk($sformatf("rr%0d_data", i), mem_request_data, (i % 2 == 0) ? 256'hD0 : 256'hD1);
      chk($sformatf("rr%0d_op", i), mem_request_op, 2'b10);
      tick();
    end
    chk("rr_count", reads_outstanding, 0);

    // ---- Grant lock: m1 read stalled 3 cycles, m0 joins in cycle 2 ----
    do_reset();
    m1_request_valid = 1; m1_request_op = 2'b01; m1_request_addr = 32'h400; m1_request_data = 256'h77;
    mem_request_ready = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin
        m0_request_valid = 1; m0_request_op = 2'b10; m0_request_addr = 32'h500; m0_request_data = 256'h99;
      end
      if (c == 3) mem_request_ready = 1;
      #1;
      chk($sformatf("lk%0d_valid", c), mem_request_valid, 1);
      chk($sformatf("lk%0d_addr", c), mem_request_addr, 32'h400);
      chk($sformatf("lk%0d_op", c), mem_request_op, 2'b01);
      chk($sformatf("lk%0d_data", c), mem_request_data, 256'h77);
      chk($sformatf("lk%0d_m0_ready", c), m0_request_ready, 0);
      chk($sformatf("lk%0d_m1_ready", c), m1_request_ready, (c == 3) ? 1 : 0);
      tick();
    end
    chk("lk_count", reads_outstanding, 1);
    m1_request_valid = 0;
    #1;
    chk("lk_m0_ready", m0_request_ready, 1);
    chk("lk_m0_addr", mem_request_addr, 32'h500);
    chk("lk_m0_op", mem_request_op, 2'b10);
    tick();
    idle_inputs();

    // ---- Target back-pressure on the outstanding m1 read ----
    mem_update_valid = 1; mem_update_data = 256'hBB;
    m0_update_ready = 1; m1_update_ready = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) m1_update_ready = 1;
      #1;
      chk($sformatf("bp%0d_mem_ready", c), mem_update_ready, (c == 2) ? 1 : 0);
      chk($sformatf("bp%0d_m1_valid", c), m1_update_valid, 1);
      chk($sformatf("bp%0d_m0_valid", c), m0_update_valid, 0);
      chk($sformatf("bp%0d_count", c), reads_outstanding, 1);
      if (c == 2) chk("bp_m1_data", m1_update_data, 256'hBB);
      tick();
    end
    chk("bp_count0", reads_outstanding, 0);
    idle_inputs();

    // ---- Read budget: four reads, fifth stalls, write still passes ----
    do_reset();
    m0_request_valid = 1; m0_request_op = 2'b01; m0_request_addr = 32'h1000;
    m1_request_valid = 1; m1_request_op = 2'b01; m1_request_addr = 32'h2000;
    mem_request_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("mr%0d_m0_ready", i), m0_request_ready, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("mr%0d_m1_ready", i), m1_request_ready, (i % 2 == 1) ? 1 : 0);
      tick();
    end
    chk("mr_count4", reads_outstanding, 4);
    m0_request_op = 2'b10; m0_request_addr = 32'h3000; m0_request_data = 256'hEE;
    #1;
    chk("mr_wr_m0_ready", m0_request_ready, 1);
    chk("mr_wr_m1_ready", m1_request_ready, 0);
    chk("mr_wr_op", mem_request_op, 2'b10);
    chk("mr_wr_addr", mem_request_addr, 32'h3000);
    tick();
    chk("mr_wr_count", reads_outstanding, 4);
    m0_request_valid = 0;
    #1;
    chk("mr_stall_valid", mem_request_valid, 0);
    chk("mr_stall_m1_ready", m1_request_ready, 0);
    // Responses D0..D4; the stalled m1 read issues in the same cycle as the
    // second response, so count holds at 3 there.
    m0_update_ready = 1; m1_update_ready = 1; mem_update_valid = 1;
    for (int r = 0; r < 5; r++) begin
      mem_update_data = 256'hD0 + DW'(r);
      if (r == 2) m1_request_valid = 0;
      #1;
      chk($sformatf("mrr%0d_m0_valid", r), m0_update_valid, (r == 0 || r == 2) ? 1 : 0);
      chk($sformatf("mrr%0d_m1_valid", r), m1_update_valid, (r == 0 || r == 2) ? 0 : 1);
      chk($sformatf("mrr%0d_data", r), (r == 0 || r == 2) ? m0_update_data : m1_update_data,
          256'hD0 + DW'(r));
      if (r == 0) chk("mrr0_m1_req_ready", m1_request_ready, 0);
      if (r == 1) chk("mrr1_m1_req_ready", m1_request_ready, 1);
      tick();
      chk($sformatf("mrr%0d_count", r), reads_outstanding,
          (r == 0) ? 3 : (r == 1) ? 3 : (r == 2) ? 2 : (r == 3) ? 1 : 0);
    end
    idle_inputs();

    // ---- Illegal op: acknowledged, dropped, pointer advances ----
    do_reset();
    m0_request_valid = 1; m0_request_op = 2'b11; m0_request_addr = 32'h600;
    mem_request_ready = 0;
    #1;
    chk("il_m0_ready", m0_request_ready, 1);
    chk("il_mem_valid", mem_request_valid, 0);
    tick();
    chk("il_count", reads_outstanding, 0);
    m0_request_op = 2'b10;
    m1_request_valid = 1; m1_request_op = 2'b10; m1_request_addr = 32'h700;
    mem_request_ready = 1;
    #1;
    chk("il_next_m1_ready", m1_request_ready, 1);
    chk("il_next_addr", mem_request_addr, 32'h700);
    tick();
    idle_inputs();

    // ---- Reset with two reads outstanding and a locked request ----
    do_reset();
    m0_request_valid = 1; m0_request_op = 2'b01; m0_request_addr = 32'h800;
    m1_request_valid = 1; m1_request_op = 2'b01; m1_request_addr = 32'h900;
    mem_request_ready = 1;
    tick();
    tick();
    m1_request_valid = 0;
    m0_request_op = 2'b10;
    mem_request_ready = 0;
    tick();
    chk("mid_count2", reads_outstanding, 2);
    chk("mid_locked_valid", mem_request_valid, 1);
    reset = 1;
    tick();
    #1;
    chk("mid_rst_count", reads_outstanding, 0);
    chk("mid_rst_mem_valid", mem_request_valid, 0);
    chk("mid_rst_m0_ready", m0_request_ready, 0);
    reset = 0;
    idle_inputs();
    mem_update_valid = 1; mem_update_data = 256'hCC;
    m0_update_ready = 1; m1_update_ready = 1;
    #1;
    chk("post_mem_upd_ready", mem_update_ready, 0);
    chk("post_m0_upd_valid", m0_update_valid, 0);
    chk("post_m1_upd_valid", m1_update_valid, 0);
    chk("post_mem_req_valid", mem_request_valid, 0);
    tick();
    chk("post_count", reads_outstanding, 0);
    chk("post_mem_upd_ready2", mem_update_ready, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
